cache_ctrl_assoc: RTL and testbench

- Parametrised successor to the direct-mapped cache controller FSM.
- Drives a WAYS-way set-associative, write-back, write-allocate cache built from per-way tag/data banks, backed by a pipelined banked memory.
- Adds:
  - victim selection across ways;
  - counted multi-word writeback and fill with fixed memory read latency;
  - memory back-pressure;
  - a single-cycle hit path;
  - real error reporting.

---
 rtl/cache_pkg.sv | 34 +++
 rtl/cache_ctrl_assoc_if.sv | 43 ++++
 rtl/mem_ret_pipe.sv | 23 ++
 rtl/cache_ctrl_assoc.sv | 174 +++++++++++++++++
 tb/tb_cache_ctrl_assoc.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache controller: state encoding,
// width derivation helpers and the victim-way selection rule.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        FILL   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int MAX_WAYS = 4;

    function automatic int off_w(input int words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

    function automatic int vic_w(input int ways);
        return (ways <= 1) ? 1 : $clog2(ways);
    endfunction

    // Lowest-indexed invalid way wins; with every way valid, fall back to the pointer.
    function automatic logic [1:0] pick_victim(input logic [MAX_WAYS-1:0] valid,
                                               input int ways,
                                               input logic [1:0] ptr);
        logic [1:0] v;
        v = ptr;
        for (int i = MAX_WAYS - 1; i >= 0; i--) begin
            if (i < ways && !valid[i]) v = 2'(i);
        end
        return v;
    endfunction

endpackage

// File: rtl/cache_ctrl_assoc_if.sv
// Controller-side bundle: CPU request, bank status/control and memory request signals.
interface cache_ctrl_assoc_if #(
    parameter int WAYS  = 2,
    parameter int WORDS = 4
);
    localparam int OFFW = cache_pkg::off_w(WORDS);

    logic            rd;
    logic            wr;
    logic [WAYS-1:0] hit;
    logic [WAYS-1:0] valid;
    logic [WAYS-1:0] dirty;
    logic            cache_err;
    logic            mem_stall;
    logic            mem_err;

    logic            comp;
    logic            cache_wr;
    logic [WAYS-1:0] way_en;
    logic [OFFW-1:0] cache_off;
    logic            mem_rd;
    logic            mem_wr;
    logic [OFFW-1:0] mem_off;
    logic            mem_victim;
    logic            fill_sel;
    logic            stall;
    logic            done;
    logic            cpu_hit;
    logic            err;

    modport master (
        input  rd, wr, hit, valid, dirty, cache_err, mem_stall, mem_err,
        output comp, cache_wr, way_en, cache_off, mem_rd, mem_wr, mem_off,
               mem_victim, fill_sel, stall, done, cpu_hit, err
    );

    modport slave (
        output rd, wr, hit, valid, dirty, cache_err, mem_stall, mem_err,
        input  comp, cache_wr, way_en, cache_off, mem_rd, mem_wr, mem_off,
               mem_victim, fill_sel, stall, done, cpu_hit, err
    );

endinterface

// File: rtl/mem_ret_pipe.sv
// Tracks accepted memory reads; a valid bit emerges MEM_LAT cycles after each issue.
module mem_ret_pipe #(
    parameter int MEM_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    input  logic flush,
    output logic ret_valid
);

    logic [MEM_LAT-1:0] sr;

    // The concatenation drops the oldest bit, which also covers MEM_LAT == 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        sr <= '0;
        else if (flush) sr <= '0;
        else            sr <= MEM_LAT'({sr, issue});
    end

    assign ret_valid = sr[MEM_LAT-1];

endmodule

// File: rtl/cache_ctrl_assoc.sv
// Write-back, write-allocate controller for a WAYS-way set-associative cache with
// counted multi-word writeback/fill against a fixed-latency, stallable memory.
module cache_ctrl_assoc
    import cache_pkg::*;
#(
    parameter int WAYS    = 2,
    parameter int WORDS   = 4,
    parameter int MEM_LAT = 4
) (
    input logic                clk,
    input logic                rst,
    cache_ctrl_assoc_if.master bus
);

    localparam int OFFW = off_w(WORDS);
    localparam int VW   = vic_w(WAYS);
    localparam int CW   = OFFW + 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    state_t          state, state_n;
    logic [CW-1:0]   iss_cnt, ret_cnt;
    logic [VW-1:0]   vic, vptr, vsel;
    logic            req_wr, err_flag;
    logic [WAYS-1:0] hv, hit_oh, vsel_oh, vic_oh;
    logic [MAX_WAYS-1:0] valid4;
    logic            vic_dirty, fault, ret_valid;
    logic            miss, iss_acc, rd_acc, ret_wr, flush, ok_done;

    mem_ret_pipe #(.MEM_LAT(MEM_LAT)) u_ret (
        .clk       (clk),
        .rst       (rst),
        .issue     (rd_acc),
        .flush     (flush),
        .ret_valid (ret_valid)
    );

    always_comb begin
        valid4 = '0;
        valid4[WAYS-1:0] = bus.valid;
        vsel = VW'(pick_victim(valid4, WAYS, 2'(vptr)));
    end

    assign hv        = bus.hit & bus.valid;
    assign hit_oh    = hv & (~hv + WAYS'(1));
    assign vsel_oh   = WAYS'(1) << vsel;
    assign vic_oh    = WAYS'(1) << vic;
    assign vic_dirty = |(vsel_oh & bus.valid & bus.dirty);
    assign fault     = bus.cache_err | bus.mem_err;

    always_comb begin
        state_n        = state;
        bus.comp       = 1'b0;
        bus.cache_wr   = 1'b0;
        bus.way_en     = '0;
        bus.cache_off  = '0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_off    = '0;
        bus.mem_victim = 1'b0;
        bus.fill_sel   = 1'b0;
        bus.stall      = 1'b0;
        bus.done       = 1'b0;
        bus.cpu_hit    = 1'b0;
        bus.err        = 1'b0;
        miss           = 1'b0;
        iss_acc        = 1'b0;
        rd_acc         = 1'b0;
        ret_wr         = 1'b0;
        flush          = 1'b0;
        ok_done        = 1'b0;
        // Outputs are forced quiet while reset is held, even with a request pending.
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (bus.rd && bus.wr) begin
                        bus.done = 1'b1;
                        bus.err  = 1'b1;
                    end else if (bus.rd || bus.wr) begin
                        bus.comp   = 1'b1;
                        bus.way_en = '1;
                        if (|hv) begin
                            bus.way_en   = hit_oh;
                            bus.cache_wr = bus.wr;
                            bus.done     = 1'b1;
                            bus.cpu_hit  = 1'b1;
                            ok_done      = 1'b1;
                        end else begin
                            bus.stall = 1'b1;
                            miss      = 1'b1;
                            state_n   = vic_dirty ? WB : FILL;
                        end
                    end
                end
                WB: begin
                    bus.stall = 1'b1;
                    if (fault) begin
                        flush   = 1'b1;
                        state_n = FINISH;
                    end else begin
                        bus.mem_wr     = 1'b1;
                        bus.mem_victim = 1'b1;
                        bus.way_en     = vic_oh;
                        bus.cache_off  = iss_cnt[OFFW-1:0];
                        bus.mem_off    = iss_cnt[OFFW-1:0];
                        iss_acc        = !bus.mem_stall;
                        if (iss_acc && iss_cnt == LAST) state_n = FILL;
                    end
                end
                FILL: begin
                    bus.stall = 1'b1;
                    if (fault) begin
                        flush   = 1'b1;
                        state_n = FINISH;
                    end else begin
                        if (iss_cnt <= LAST) begin
                            bus.mem_rd  = 1'b1;
                            bus.mem_off = iss_cnt[OFFW-1:0];
                            iss_acc     = !bus.mem_stall;
                            rd_acc      = iss_acc;
                        end
                        if (ret_valid) begin
                            bus.cache_wr  = 1'b1;
                            bus.fill_sel  = 1'b1;
                            bus.way_en    = vic_oh;
                            bus.cache_off = ret_cnt[OFFW-1:0];
                            ret_wr        = 1'b1;
                            if (ret_cnt == LAST) state_n = FINISH;
                        end
                    end
                end
                FINISH: begin
                    bus.comp     = 1'b1;
                    bus.way_en   = vic_oh;
                    bus.done     = 1'b1;
                    bus.stall    = 1'b1;
                    bus.err      = err_flag;
                    bus.cache_wr = req_wr && !err_flag;
                    ok_done      = !err_flag;
                    state_n      = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            iss_cnt  <= '0;
            ret_cnt  <= '0;
            vic      <= '0;
            vptr     <= '0;
            req_wr   <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            state <= state_n;
            if (miss) begin
                vic    <= vsel;
                req_wr <= bus.wr;
            end
            if (flush || state == FINISH) begin
                iss_cnt <= '0;
                ret_cnt <= '0;
            end else begin
                // The issue counter is reused: cleared between writeback and fill.
                if (iss_acc) iss_cnt <= (state == WB && iss_cnt == LAST) ? '0 : iss_cnt + CW'(1);
                if (ret_wr)  ret_cnt <= ret_cnt + CW'(1);
            end
            if (flush)                err_flag <= 1'b1;
            else if (state == FINISH) err_flag <= 1'b0;
            if (ok_done && WAYS > 1)  vptr <= vptr + VW'(1);
        end
    end

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Directed bench: single-cycle IDLE vectors from a table, then cycle-exact miss sequences.
module tb_cache_ctrl_assoc;
    import cache_pkg::*;

    localparam int WAYS    = 2;
    localparam int WORDS   = 4;
    localparam int MEM_LAT = 4;
    localparam int OFFW    = off_w(WORDS);
    localparam int OW      = 10 + WAYS + 2 * OFFW;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cache_ctrl_assoc_if #(.WAYS(WAYS), .WORDS(WORDS)) bus ();

    cache_ctrl_assoc #(.WAYS(WAYS), .WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic            rd;
        logic            wr;
        logic [WAYS-1:0] hit;
        logic [WAYS-1:0] valid;
        logic [OW-1:0]   exp;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [OW-1:0] mk(input logic comp, input logic cwr,
                                         input logic [WAYS-1:0] we, input logic [OFFW-1:0] co,
                                         input logic mrd, input logic mwr, input logic [OFFW-1:0] mo,
                                         input logic mv, input logic fs, input logic st,
                                         input logic dn, input logic ch, input logic er);
        return {comp, cwr, we, co, mrd, mwr, mo, mv, fs, st, dn, ch, er};
    endfunction

    function automatic logic [OW-1:0] outs();
        return {bus.comp, bus.cache_wr, bus.way_en, bus.cache_off, bus.mem_rd, bus.mem_wr,
                bus.mem_off, bus.mem_victim, bus.fill_sel, bus.stall, bus.done, bus.cpu_hit, bus.err};
    endfunction

    function automatic vec_t mkv(input string n, input logic rd, input logic wr,
                                 input logic [WAYS-1:0] hit, input logic [WAYS-1:0] valid,
                                 input logic [OW-1:0] exp);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.hit = hit; v.valid = valid; v.exp = exp;
        return v;
    endfunction

    task automatic tick(input string name, input logic [OW-1:0] exp);
        logic [OW-1:0] got;
        @(negedge clk);
        got = outs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clean_rd_miss(input string tag);
        bus.rd = 1'b1; bus.wr = 1'b0; bus.hit = '0; bus.valid = '0; bus.dirty = '0;
        tick({tag, " lookup"}, mk(1, 0, '1, '0, 0, 0, '0, 0, 0, 1, 0, 0, 0));
        for (int k = 0; k < WORDS; k++)
            tick($sformatf("%s issue %0d", tag, k), mk(0, 0, '0, '0, 1, 0, OFFW'(k), 0, 0, 1, 0, 0, 0));
        for (int k = 0; k < WORDS; k++)
            tick($sformatf("%s fill %0d", tag, k), mk(0, 1, 2'b01, OFFW'(k), 0, 0, '0, 0, 1, 1, 0, 0, 0));
        tick({tag, " finish"}, mk(1, 0, 2'b01, '0, 0, 0, '0, 0, 0, 1, 1, 0, 0));
        bus.rd = 1'b0;
    endtask

    task automatic dirty_miss(input string tag, input logic is_wr,
                              input logic [WAYS-1:0] vw, input int nstall);
        int wb_len;
        int off;
        wb_len = WORDS + nstall;
        bus.rd = !is_wr; bus.wr = is_wr; bus.hit = '0; bus.valid = '1; bus.dirty = '1;
        tick({tag, " lookup"}, mk(1, 0, '1, '0, 0, 0, '0, 0, 0, 1, 0, 0, 0));
        for (int c = 1; c <= wb_len; c++) begin
            bus.mem_stall = (c >= 2 && c < 2 + nstall);
            off = (c - 1) - ((c < 2) ? 0 : ((c - 2 > nstall) ? nstall : c - 2));
            tick($sformatf("%s wb c%0d", tag, c), mk(0, 0, vw, OFFW'(off), 0, 1, OFFW'(off), 1, 0, 1, 0, 0, 0));
        end
        bus.mem_stall = 1'b0;
        for (int k = 0; k < WORDS; k++)
            tick($sformatf("%s issue %0d", tag, k), mk(0, 0, '0, '0, 1, 0, OFFW'(k), 0, 0, 1, 0, 0, 0));
        for (int k = 0; k < WORDS; k++)
            tick($sformatf("%s fill %0d", tag, k), mk(0, 1, vw, OFFW'(k), 0, 0, '0, 0, 1, 1, 0, 0, 0));
        tick({tag, " finish"}, mk(1, is_wr, vw, '0, 0, 0, '0, 0, 0, 1, 1, 0, 0));
        bus.rd = 1'b0; bus.wr = 1'b0;
        tick({tag, " idle"}, '0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.rd = 1'b1; bus.wr = 1'b0; bus.hit = '0; bus.valid = '0; bus.dirty = '0;
        bus.cache_err = 1'b0; bus.mem_stall = 1'b0; bus.mem_err = 1'b0;
        tick("reset quiet", '0);
        rst = 1'b0;
        bus.rd = 1'b0;

        // Victim pointer: 0 -> 1 -> 0 -> 1 -> (rd&wr, no change) -> 0
        tbl[0] = mkv("idle",      0, 0, 2'b00, 2'b00, '0);
        tbl[1] = mkv("rd hit w0", 1, 0, 2'b01, 2'b11, mk(1, 0, 2'b01, '0, 0, 0, '0, 0, 0, 0, 1, 1, 0));
        tbl[2] = mkv("wr hit w1", 0, 1, 2'b10, 2'b11, mk(1, 1, 2'b10, '0, 0, 0, '0, 0, 0, 0, 1, 1, 0));
        tbl[3] = mkv("rd hit vq", 1, 0, 2'b11, 2'b10, mk(1, 0, 2'b10, '0, 0, 0, '0, 0, 0, 0, 1, 1, 0));
        tbl[4] = mkv("rd+wr err", 1, 1, 2'b11, 2'b11, mk(0, 0, 2'b00, '0, 0, 0, '0, 0, 0, 0, 1, 0, 1));
        tbl[5] = mkv("wr hit lo", 0, 1, 2'b11, 2'b11, mk(1, 1, 2'b01, '0, 0, 0, '0, 0, 0, 0, 1, 1, 0));
        for (int i = 0; i < 6; i++) begin
            bus.rd = tbl[i].rd; bus.wr = tbl[i].wr;
            bus.hit = tbl[i].hit; bus.valid = tbl[i].valid; bus.dirty = '0;
            tick(tbl[i].name, tbl[i].exp);
        end
        bus.rd = 1'b0; bus.wr = 1'b0;

        clean_rd_miss("clean");                 // pointer 0 -> 1
        dirty_miss("dirty wr", 1'b1, 2'b10, 0); // pointer 1 -> 0
        dirty_miss("stalled", 1'b0, 2'b01, 2);  // pointer 0 -> 1

        // Memory error two cycles into a fill, then a miss that must not see stale returns.
        bus.wr = 1'b1; bus.rd = 1'b0; bus.hit = '0; bus.valid = '0; bus.dirty = '0;
        tick("err lookup", mk(1, 0, '1, '0, 0, 0, '0, 0, 0, 1, 0, 0, 0));
        tick("err issue 0", mk(0, 0, '0, '0, 1, 0, OFFW'(0), 0, 0, 1, 0, 0, 0));
        tick("err issue 1", mk(0, 0, '0, '0, 1, 0, OFFW'(1), 0, 0, 1, 0, 0, 0));
        bus.mem_err = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_err = 1'b0;
        tick("err finish", mk(1, 0, 2'b01, '0, 0, 0, '0, 0, 0, 1, 1, 0, 1));
        bus.wr = 1'b0;
        clean_rd_miss("after err");

        // Reset after two fill returns, then a clean miss from scratch.
        bus.rd = 1'b1; bus.wr = 1'b0; bus.hit = '0; bus.valid = '0; bus.dirty = '0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
        end
        tick("pre-rst fill 0", mk(0, 1, 2'b01, OFFW'(0), 0, 0, '0, 0, 1, 1, 0, 0, 0));
        tick("pre-rst fill 1", mk(0, 1, 2'b01, OFFW'(1), 0, 0, '0, 0, 1, 1, 0, 0, 0));
        rst = 1'b1;
        #1;
        tick("mid-op reset", '0);
        rst = 1'b0;
        clean_rd_miss("post-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
